// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the FP normalise/round block
package fp_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      FP_ZERO = 32'h0000_0000;
  localparam logic [31:0]      FP_INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, FP_INF[30:0]};
  endfunction
endpackage

// File: rtl/fp_round_inc.sv
// rtl/fp_round_inc.sv - mantissa incrementer built as a ripple of half-adder cells
module fp_round_inc
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  input  logic              cin,
  output logic [MANT_W-1:0] sum,
  output logic              cout
);
  logic [MANT_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < MANT_W; i++) begin : g_ha
    assign sum[i]       = a[i] ^ carry[i];
    assign carry[i+1]   = a[i] & carry[i];
  end

  assign cout = carry[MANT_W];
endmodule

// File: rtl/fp_norm_round.sv
// rtl/fp_norm_round.sv - normalises a raw mantissa sum one bit per cycle and rounds to nearest-even
module fp_norm_round
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [24:0] in_sum,
  input  logic [7:0]  in_exp,
  input  logic        in_sign,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_overflow,
  output logic        out_underflow
);
  state_t             state_q, state_d;
  logic [MANT_W:0]    mant_q, mant_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               sign_q, sign_d;
  logic               guard_q, guard_d;
  logic [31:0]        result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;

  logic [MANT_W-1:0]  inc_sum;
  logic               inc_cout;

  // Ties round up only when the dropped guard bit is set and the kept LSB is odd.
  fp_round_inc u_round_inc (
    .a    (mant_q[MANT_W-1:0]),
    .cin  (guard_q & mant_q[0]),
    .sum  (inc_sum),
    .cout (inc_cout)
  );

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    guard_d  = guard_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    valid_d  = valid_q;
    ready_d  = ready_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && ready_q) begin
          mant_d  = in_sum;
          exp_d   = in_exp;
          sign_d  = in_sign;
          guard_d = 1'b0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          ready_d = 1'b0;
          state_d = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mant_q == '0) begin
          result_d = FP_ZERO;
          zero_d   = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (exp_q == EXP_MAX) begin
          result_d = fp_inf(sign_q);
          ovf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end else if (mant_q[MANT_W]) begin
          mant_d  = {1'b0, mant_q[MANT_W:1]};
          guard_d = mant_q[0];
          exp_d   = exp_q + 8'd1;
          if (exp_q == EXP_MAX - 8'd1) begin
            result_d = fp_inf(sign_q);
            ovf_d    = 1'b1;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_ROUND;
          end
        end else if (mant_q[MANT_W-1]) begin
          guard_d = 1'b0;
          state_d = ST_ROUND;
        end else if (exp_q > 8'd1) begin
          mant_d = {mant_q[MANT_W-1:0], 1'b0};
          exp_d  = exp_q - 8'd1;
        end else begin
          result_d = {sign_q, 31'b0};
          unf_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_ROUND: begin
        mant_d  = {inc_cout, inc_sum};
        valid_d = 1'b1;
        state_d = ST_DONE;
        // A carry out of the incrementer leaves 1.000..0, so only the exponent moves.
        if (inc_cout) begin
          exp_d = exp_q + 8'd1;
          if (exp_q == EXP_MAX - 8'd1) begin
            result_d = fp_inf(sign_q);
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_q + 8'd1, 23'h0};
          end
        end else begin
          result_d = {sign_q, exp_q, inc_sum[MANT_W-2:0]};
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      guard_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      guard_q  <= guard_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready      = ready_q;
  assign out_valid     = valid_q;
  assign out_result    = result_q;
  assign out_zero      = zero_q;
  assign out_overflow  = ovf_q;
  assign out_underflow = unf_q;
endmodule

// File: tb/tb_fp_norm_round.sv
// tb/tb_fp_norm_round.sv - scoreboard bench for fp_norm_round
module tb_fp_norm_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_sum;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] result;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  fp_norm_round dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sum        (in_sum),
    .in_exp        (in_exp),
    .in_sign       (in_sign),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // flags packed as {zero, overflow, underflow}; latency counted in cycles after the accept cycle
  function automatic exp_t model(input logic [24:0] s, input logic [7:0] e, input logic sg);
    exp_t r;
    logic [24:0] m;
    int ex, k;
    logic g;
    m = s; ex = e; k = 0; g = 1'b0;
    if (s == 25'd0) begin
      r.result = 32'h0; r.flags = 3'b100; r.lat = 2;
      return r;
    end
    if (e == 8'hFF) begin
      r.result = {sg, 31'h7F800000}; r.flags = 3'b010; r.lat = 2;
      return r;
    end
    if (m[24]) begin
      g = m[0]; m = m >> 1; ex = ex + 1;
      if (ex == 255) begin
        r.result = {sg, 31'h7F800000}; r.flags = 3'b010; r.lat = 2;
        return r;
      end
    end else begin
      while (!m[23]) begin
        if (ex <= 1) begin
          r.result = {sg, 31'b0}; r.flags = 3'b001; r.lat = 2 + k;
          return r;
        end
        m = m << 1; ex = ex - 1; k++;
      end
    end
    if (g && m[0]) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1; ex = ex + 1;
    end
    r.lat = 3 + k;
    if (ex == 255) begin
      r.result = {sg, 31'h7F800000}; r.flags = 3'b010;
    end else begin
      r.result = {sg, ex[7:0], m[22:0]}; r.flags = 3'b000;
    end
    return r;
  endfunction

  task automatic run_op(input logic [24:0] s, input logic [7:0] e, input logic sg, input int hold);
    exp_t w;
    logic [31:0] held;
    int n, g;
    sb_q.push_back(model(s, e, sg));
    @(negedge clk);
    in_sum = s; in_exp = e; in_sign = sg; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_ready", {31'b0, in_ready}, 32'd0);
    chk("flags_clr", {29'b0, out_zero, out_overflow, out_underflow}, 32'd0);
    n = 1;
    while (!out_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", {31'b0, out_valid}, 32'd1);
    w = sb_q.pop_front();
    chk("result", out_result, w.result);
    chk("flags", {29'b0, out_zero, out_overflow, out_underflow}, {29'b0, w.flags});
    chk("latency", n, w.lat);
    held = out_result;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", out_result, held);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready", {31'b0, in_ready}, 32'd1);
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0; in_sign = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {29'b0, out_zero, out_overflow, out_underflow}, 32'd0);

    run_op(25'h0800000, 8'd127, 1'b0, 0);
    chk("one_const", out_result, 32'h3F800000);
    run_op(25'h1000000, 8'd127, 1'b0, 0);
    chk("two_const", out_result, 32'h40000000);
    run_op(25'h1FFFFFF, 8'd127, 1'b0, 0);
    chk("rcarry_const", out_result, 32'h40800000);
    run_op(25'h0400000, 8'd127, 1'b0, 1);
    chk("half_const", out_result, 32'h3F000000);
    run_op(25'h0000000, 8'd127, 1'b0, 0);
    chk("zero_const", {out_result[31:1], out_zero}, 32'h1);
    run_op(25'h1000000, 8'd254, 1'b0, 0);
    chk("ovf_const", {out_result[31:1], out_overflow}, {31'h3FC00000, 1'b1});
    run_op(25'h0000001, 8'd5, 1'b1, 0);
    chk("unf_const", {out_result[31:1], out_underflow}, {31'h40000000, 1'b1});
    run_op(25'h0000001, 8'd200, 1'b0, 0);
    run_op(25'h0C00001, 8'd255, 1'b1, 0);
    run_op(25'h1000003, 8'd100, 1'b1, 0);
    run_op(25'h1000001, 8'd100, 1'b0, 0);
    run_op(25'h1FFFFFF, 8'd253, 1'b0, 0);
    run_op(25'h0123456, 8'd90, 1'b0, 10);

    for (int i = 0; i < 25; i++) begin
      logic [24:0] s;
      s = 25'($urandom) >> $urandom_range(0, 24);
      run_op(s, 8'($urandom_range(0, 255)), 1'($urandom), $urandom_range(0, 3));
    end

    // reset while NORM is still shifting a tiny operand
    @(negedge clk);
    in_sum = 25'h0000001; in_exp = 8'd100; in_sign = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) chk("no_output_after_rst", {31'b0, out_valid}, 32'd0);
    end
    chk("rst_idle_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_result_clr", out_result, 32'h0);
    run_op(25'h0800000, 8'd127, 1'b0, 0);
    chk("post_rst_const", out_result, 32'h3F800000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_norm_round.md
FP_NORM_ROUND -- requirements
Module: fp_norm_round

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  in  1  in_sum/in_exp/in_sign offered.
REQ-004 SHALL have port: in_ready  out  1  block accepts input; high only in IDLE.
REQ-005 SHALL have port: in_sum  in  25  raw mantissa adder result; bit 24 = carry-out, bit 23 = hidden-1 position.
REQ-006 SHALL have port: in_exp  in  8  biased exponent of the aligned operands.
REQ-007 SHALL have port: in_sign  in  1  result sign.
REQ-008 SHALL have port: out_valid  out  1  out_result valid; held until out_ready.
REQ-009 SHALL have port: out_ready  in  1  downstream accepts the result.
REQ-010 SHALL have port: out_result  out  32  IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-011 SHALL have port: out_zero, out_overflow, out_underflow  out  1 each  status flags, valid with out_valid.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-013 SHALL capture inputs in IDLE when in_valid&&in_ready, then go to NORM.
REQ-014 NORM SHALL handle in_sum==0 as: result 32'h00000000, out_zero=1, go to DONE.
REQ-015 NORM SHALL handle in_exp==255 as: result {sign,8'hFF,23'h0}, out_overflow=1, go to DONE.
REQ-016 NORM with bit24 set SHALL shift mantissa right by 1, save the dropped bit as guard, set exp+1, and go to ROUND; if exp+1==255, it SHALL instead produce infinity with out_overflow and go to DONE.
REQ-017 NORM with bit23 set SHALL go to ROUND with guard=0.
REQ-018 NORM with bits 24:23 clear and exp>1 SHALL shift left by 1, set exp-1, and stay in NORM; exactly one shift occurs per cycle.
REQ-019 NORM with bits 24:23 clear and exp<=1 SHALL flush to {sign,31'b0}, set out_underflow=1, and go to DONE.
REQ-020 ROUND SHALL use round-to-nearest-even with no sticky: if guard=1 and mantissa LSB=1, increment the mantissa.
REQ-021 If the increment carries to 2^24, ROUND SHALL shift right by 1 and set exp+1; if exp reaches 255, the result SHALL be infinity with out_overflow=1.
REQ-022 ROUND SHALL pack {sign,exp,mant[22:0]} into out_result and go to DONE.
REQ-023 DONE SHALL assert out_valid; on out_ready it SHALL go to IDLE, and all outputs SHALL be held stable until then.
REQ-024 Latency SHALL be 3+k cycles from the accept edge to out_valid, where k = number of left shifts (k<=23).
REQ-025 in_ready SHALL be 0 outside IDLE; a new accept is possible no earlier than the cycle after the DONE handshake.
REQ-026 Flags SHALL be mutually exclusive and cleared on every accept.

Reset
REQ-027 rst SHALL force, asynchronously: state=IDLE, in_ready=1 after release, out_valid=0, out_result=0, all flags=0.
REQ-028 Reset mid-operation SHALL discard the in-flight operand with no output produced.

Structure
REQ-029 Shared package fp_pkg SHALL hold: state enum, MANT_W=24, EXP_W=8, EXP_MAX=8'hFF, FP_INF/FP_ZERO constants.
REQ-030 The 24-bit round incrementer SHALL be a separate sub-module, fp_round_inc (ripple of half-adder cells, carry-out exposed).

Verification
REQ-031 in_sum=25'h0800000, exp=127, sign=0 -> out_result=32'h3F800000 at T+3, no flags.
REQ-032 in_sum=25'h1000000, exp=127 -> 32'h40000000; in_sum=25'h1FFFFFF, exp=127 -> round carry, 32'h40800000.
REQ-033 in_sum=25'h0400000, exp=127 -> 32'h3F000000 at T+4; in_sum=0 -> 32'h00000000, out_zero=1.
REQ-034 in_sum=25'h1000000, exp=254 -> 32'h7F800000, out_overflow=1; in_sum=25'h0000001, exp=5, sign=1 -> 32'h80000000, out_underflow=1.
REQ-035 out_ready held low 10 cycles -> out_valid and out_result stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-036 rst pulsed during NORM shifting -> out_valid stays 0; the next operand completes correctly.
